// File: rtl/branch_sequencer.sv
// branch_sequencer: program-counter sequencer with conditional branches on
// latched ALU flags and an optional return-address stack.
// Optional feature macro: BRANCH_STACK_EN. When it is defined, the design has
// a stack, CALL/RET, occupancy outputs and a sticky error. When it is not
// defined, there is no stack: CALL acts as GOTO, RET acts as NEXT, and the
// stack outputs are held at constant values.
module branch_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_PC    = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_en,
    input  logic [2:0]                     i_opcode,
    input  logic [ADDR_W-1:0]              i_target,
    input  logic [2:0]                     i_status,
    input  logic                           i_flag_we,
    output logic [ADDR_W-1:0]              o_pc,
    output logic                           o_jump,
    output logic [2:0]                     o_flags,
    output logic [$clog2(STACK_DEPTH):0]   o_depth,
    output logic                           o_full,
    output logic                           o_empty,
    output logic                           o_err
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;

    typedef enum logic [2:0] {
        OP_NEXT   = 3'b000,
        OP_GOTO   = 3'b001,
        OP_GTIFZ  = 3'b010,
        OP_GTIFN  = 3'b011,
        OP_GTIFC  = 3'b100,
        OP_GTIFNZ = 3'b101,
        OP_CALL   = 3'b110,
        OP_RET    = 3'b111
    } opcode_e;

    opcode_e            op;
    logic [2:0]         flags_q, flags_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_inc;
    logic               take;
    logic               jump;

    assign op     = opcode_e'(i_opcode);
    assign pc_inc = pc_q + ADDR_W'(1);

`ifdef BRANCH_STACK_EN
    logic [ADDR_W-1:0]  stack_q [STACK_DEPTH];
    logic [ADDR_W-1:0]  stack_d [STACK_DEPTH];
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic [DEPTH_W-1:0] depth_m1;
    logic               err_q, err_d;
    logic               stack_full;
    logic               stack_empty;
    logic               stack_fault;
    logic [ADDR_W-1:0]  ret_addr;

    assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign stack_empty = (depth_q == '0);
    assign depth_m1    = depth_q - DEPTH_W'(1);

    // Top-of-stack read: the entry just below the occupancy count.
    always_comb begin
        ret_addr = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_m1 == DEPTH_W'(i)) begin
                ret_addr = stack_q[i];
            end
        end
    end
`endif

    // Opcode decode: branch condition uses the flags registered before this edge.
    always_comb begin
        take = 1'b0;
`ifdef BRANCH_STACK_EN
        stack_fault = 1'b0;
`endif
        case (op)
            OP_NEXT:   take = 1'b0;
            OP_GOTO:   take = 1'b1;
            OP_GTIFZ:  take = flags_q[0];
            OP_GTIFN:  take = flags_q[1];
            OP_GTIFC:  take = flags_q[2];
            OP_GTIFNZ: take = ~flags_q[0];
`ifdef BRANCH_STACK_EN
            OP_CALL: begin
                take        = ~stack_full;
                stack_fault = stack_full;
            end
            OP_RET: begin
                take        = ~stack_empty;
                stack_fault = stack_empty;
            end
`else
            OP_CALL:   take = 1'b1;
            OP_RET:    take = 1'b0;
`endif
            default:   take = 1'b0;
        endcase
        jump = i_en & take;
    end

    // Next PC and flag register.
    always_comb begin
        pc_d    = pc_q;
        flags_d = i_flag_we ? i_status : flags_q;
        if (i_en) begin
            pc_d = jump ? i_target : pc_inc;
`ifdef BRANCH_STACK_EN
            if (jump && op == OP_RET) begin
                pc_d = ret_addr;
            end
`endif
        end
    end

`ifdef BRANCH_STACK_EN
    // Stack push/pop and sticky error on illegal CALL/RET.
    always_comb begin
        stack_d = stack_q;
        depth_d = depth_q;
        err_d   = err_q;
        if (jump && op == OP_CALL) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (depth_q == DEPTH_W'(i)) begin
                    stack_d[i] = pc_inc;
                end
            end
            depth_d = depth_q + DEPTH_W'(1);
        end
        if (jump && op == OP_RET) begin
            depth_d = depth_m1;
        end
        if (i_en && stack_fault) begin
            err_d = 1'b1;
        end
    end

    // Stack storage is not reset; its contents are meaningless once depth is zero.
    always_ff @(posedge i_clk) begin
        stack_q <= stack_d;
    end

    // Stack occupancy and error registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    assign o_depth = depth_q;
    assign o_full  = stack_full;
    assign o_empty = stack_empty;
    assign o_err   = err_q;
`else
    assign o_depth = '0;
    assign o_full  = 1'b0;
    assign o_empty = 1'b1;
    assign o_err   = 1'b0;
`endif

    // PC and flag registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pc_q    <= ADDR_W'(RESET_PC);
            flags_q <= 3'b000;
        end else begin
            pc_q    <= pc_d;
            flags_q <= flags_d;
        end
    end

    assign o_pc    = pc_q;
    assign o_flags = flags_q;
    assign o_jump  = jump;

endmodule

// File: tb/tb_branch_sequencer.sv
// Testbench for branch_sequencer: fixed vector table, directed multi-cycle
// sequences, then random stimulus against a queue-based reference model.
module tb_branch_sequencer;

    localparam int ADDR_W      = 8;
    localparam int STACK_DEPTH = 4;
    localparam int RESET_PC    = 0;
    localparam int DEPTH_W     = $clog2(STACK_DEPTH) + 1;

`ifdef BRANCH_STACK_EN
    localparam bit STACK_ON = 1'b1;
`else
    localparam bit STACK_ON = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                i_rst, i_en, i_flag_we;
    logic [2:0]          i_opcode, i_status;
    logic [ADDR_W-1:0]   i_target;
    logic [ADDR_W-1:0]   o_pc;
    logic                o_jump, o_full, o_empty, o_err;
    logic [2:0]          o_flags;
    logic [DEPTH_W-1:0]  o_depth;

    always #5 clk = ~clk;

    branch_sequencer #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH),
        .RESET_PC    (RESET_PC)
    ) dut (
        .i_clk     (clk),
        .i_rst     (i_rst),
        .i_en      (i_en),
        .i_opcode  (i_opcode),
        .i_target  (i_target),
        .i_status  (i_status),
        .i_flag_we (i_flag_we),
        .o_pc      (o_pc),
        .o_jump    (o_jump),
        .o_flags   (o_flags),
        .o_depth   (o_depth),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_err     (o_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    int       m_pc;
    bit [2:0] m_flags;
    int       m_stack[$];
    bit       m_err;

    typedef struct packed {
        bit       rst;
        bit       en;
        bit [2:0] op;
        bit [7:0] tgt;
        bit [2:0] st;
        bit       fwe;
        bit [7:0] exp_pc;
        bit       exp_jump;
        bit [2:0] exp_flags;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_jump(input bit en, input bit [2:0] op);
        if (!en) return 1'b0;
        case (op)
            3'd0: return 1'b0;
            3'd1: return 1'b1;
            3'd2: return m_flags[0];
            3'd3: return m_flags[1];
            3'd4: return m_flags[2];
            3'd5: return !m_flags[0];
            3'd6: return STACK_ON ? (m_stack.size() < STACK_DEPTH) : 1'b1;
            default: return STACK_ON ? (m_stack.size() > 0) : 1'b0;
        endcase
    endfunction

    // One clock step: drive, check o_jump before the edge, advance model, check registers.
    task automatic apply(input bit rst, input bit en, input bit [2:0] op, input bit [7:0] tgt,
                         input bit [2:0] st, input bit fwe, output logic jmp_seen);
        bit j;
        int nxt;
        @(negedge clk);
        i_rst     = rst;
        i_en      = en;
        i_opcode  = op;
        i_target  = tgt;
        i_status  = st;
        i_flag_we = fwe;
        #1;
        j        = model_jump(en, op);
        jmp_seen = o_jump;
        chk("jump", o_jump, j);
        @(posedge clk);
        #1;
        if (rst) begin
            m_pc    = RESET_PC;
            m_flags = 3'b000;
            m_stack.delete();
            m_err   = 1'b0;
        end else begin
            if (en) begin
                nxt = (m_pc + 1) % (1 << ADDR_W);
                if (STACK_ON && op == 3'd6) begin
                    if (j) begin
                        m_stack.push_back(nxt);
                        m_pc = tgt;
                    end else begin
                        m_err = 1'b1;
                        m_pc  = nxt;
                    end
                end else if (STACK_ON && op == 3'd7) begin
                    if (j) m_pc = m_stack.pop_back();
                    else begin
                        m_err = 1'b1;
                        m_pc  = nxt;
                    end
                end else begin
                    m_pc = j ? int'(tgt) : nxt;
                end
            end
            if (fwe) m_flags = st;
        end
        chk("pc",    o_pc,    m_pc);
        chk("flags", o_flags, m_flags);
        chk("depth", o_depth, m_stack.size());
        chk("full",  o_full,  m_stack.size() == STACK_DEPTH);
        chk("empty", o_empty, m_stack.size() == 0);
        chk("err",   o_err,   m_err);
    endtask

    initial begin
        logic js;
        logic [7:0] held_pc;
        logic [7:0] exp_call_pc[5];
        logic [7:0] exp_ret_pc[5];
        logic       exp_call_j[5];
        logic       exp_ret_j[5];

        i_rst = 1'b1; i_en = 1'b0; i_opcode = 3'd0; i_target = '0;
        i_status = 3'd0; i_flag_we = 1'b0;
        m_pc = RESET_PC; m_flags = 3'b000; m_err = 1'b0;

        //            rst en op    tgt    st      fwe  pc     jmp  flags
        tbl[0]  = '{1'b1, 1'b0, 3'd0, 8'h00, 3'b000, 1'b0, 8'h00, 1'b0, 3'b000};
        tbl[1]  = '{1'b0, 1'b1, 3'd0, 8'h00, 3'b000, 1'b0, 8'h01, 1'b0, 3'b000};
        tbl[2]  = '{1'b0, 1'b1, 3'd1, 8'h20, 3'b000, 1'b0, 8'h20, 1'b1, 3'b000};
        tbl[3]  = '{1'b0, 1'b1, 3'd2, 8'h40, 3'b001, 1'b1, 8'h21, 1'b0, 3'b001};
        tbl[4]  = '{1'b0, 1'b1, 3'd2, 8'h40, 3'b000, 1'b0, 8'h40, 1'b1, 3'b001};
        tbl[5]  = '{1'b0, 1'b1, 3'd5, 8'h50, 3'b000, 1'b0, 8'h41, 1'b0, 3'b001};
        tbl[6]  = '{1'b0, 1'b0, 3'd1, 8'h33, 3'b110, 1'b1, 8'h41, 1'b0, 3'b110};
        tbl[7]  = '{1'b0, 1'b1, 3'd3, 8'h60, 3'b000, 1'b0, 8'h60, 1'b1, 3'b110};
        tbl[8]  = '{1'b0, 1'b1, 3'd4, 8'h70, 3'b000, 1'b0, 8'h70, 1'b1, 3'b110};
        tbl[9]  = '{1'b0, 1'b1, 3'd5, 8'h05, 3'b000, 1'b0, 8'h05, 1'b1, 3'b110};
        tbl[10] = '{1'b0, 1'b1, 3'd2, 8'h99, 3'b000, 1'b0, 8'h06, 1'b0, 3'b110};
        tbl[11] = '{1'b0, 1'b1, 3'd1, 8'hFF, 3'b000, 1'b0, 8'hFF, 1'b1, 3'b110};
        tbl[12] = '{1'b0, 1'b1, 3'd0, 8'h00, 3'b000, 1'b0, 8'h00, 1'b0, 3'b110};
        tbl[13] = '{1'b0, 1'b1, 3'd3, 8'h80, 3'b000, 1'b1, 8'h80, 1'b1, 3'b000};
        tbl[14] = '{1'b0, 1'b1, 3'd3, 8'h90, 3'b000, 1'b0, 8'h81, 1'b0, 3'b000};
        tbl[15] = '{1'b1, 1'b1, 3'd3, 8'h55, 3'b111, 1'b1, 8'h00, 1'b0, 3'b000};

        apply(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, js);
        chk("reset_pc",    o_pc,    RESET_PC);
        chk("reset_empty", o_empty, 1'b1);

        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].rst, tbl[i].en, tbl[i].op, tbl[i].tgt, tbl[i].st, tbl[i].fwe, js);
            chk($sformatf("tbl%0d_jump", i),  js,      tbl[i].exp_jump);
            chk($sformatf("tbl%0d_pc", i),    o_pc,    tbl[i].exp_pc);
            chk($sformatf("tbl%0d_flags", i), o_flags, tbl[i].exp_flags);
        end

        // 256 NEXT steps wrap the PC back to zero without error
        apply(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, js);
        for (int k = 0; k < 256; k++) begin
            apply(1'b0, 1'b1, 3'd0, 8'h00, 3'd0, 1'b0, js);
            chk("wrap_pc", o_pc, (k + 1) % 256);
        end
        chk("wrap_err", o_err, 1'b0);

        // enable low holds everything
        held_pc = o_pc;
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 1'b0, 3'd1, 8'h33, 3'd0, 1'b0, js);
            chk("hold_jump", js, 1'b0);
            chk("hold_pc", o_pc, held_pc);
        end

        // single CALL / RET
        apply(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, js);
        apply(1'b0, 1'b1, 3'd1, 8'h10, 3'd0, 1'b0, js);
        apply(1'b0, 1'b1, 3'd6, 8'h80, 3'd0, 1'b0, js);
        chk("call_pc",    o_pc,    8'h80);
        chk("call_depth", o_depth, STACK_ON ? 1 : 0);
        apply(1'b0, 1'b1, 3'd7, 8'h00, 3'd0, 1'b0, js);
        chk("ret_pc",    o_pc,    STACK_ON ? 8'h11 : 8'h81);
        chk("ret_depth", o_depth, 0);

        // overflow then underflow
        if (STACK_ON) begin
            exp_call_pc = '{8'h80, 8'h90, 8'hA0, 8'hB0, 8'hB1};
            exp_call_j  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            exp_ret_pc  = '{8'hA1, 8'h91, 8'h81, 8'h01, 8'h02};
            exp_ret_j   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        end else begin
            exp_call_pc = '{8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0};
            exp_call_j  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
            exp_ret_pc  = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
            exp_ret_j   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        end
        apply(1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, js);
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, 1'b1, 3'd6, 8'(8'h80 + 16 * k), 3'd0, 1'b0, js);
            chk($sformatf("call%0d_jump", k), js,   exp_call_j[k]);
            chk($sformatf("call%0d_pc", k),   o_pc, exp_call_pc[k]);
        end
        chk("ovf_full", o_full, STACK_ON);
        chk("ovf_err",  o_err,  STACK_ON);
        for (int k = 0; k < 5; k++) begin
            apply(1'b0, 1'b1, 3'd7, 8'h00, 3'd0, 1'b0, js);
            chk($sformatf("ret%0d_jump", k), js,   exp_ret_j[k]);
            chk($sformatf("ret%0d_pc", k),   o_pc, exp_ret_pc[k]);
        end
        chk("unf_err", o_err, STACK_ON);

        // reset during a CALL sequence
        apply(1'b0, 1'b1, 3'd6, 8'h44, 3'd0, 1'b0, js);
        apply(1'b1, 1'b1, 3'd6, 8'h66, 3'd5, 1'b1, js);
        chk("rst_call_pc",    o_pc,    RESET_PC);
        chk("rst_call_depth", o_depth, 0);
        chk("rst_call_err",   o_err,   1'b0);
        chk("rst_call_flags", o_flags, 3'b000);

        // random stimulus against the model
        for (int k = 0; k < 4000; k++) begin
            apply(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80),
                  3'($urandom_range(0, 7)), 8'($urandom), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 99) < 30), js);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, program-counter and target width.
REQ-002 Parameter STACK_DEPTH, default 4, return-address stack entries (power of two, min 2).
REQ-003 Parameter RESET_PC, default 0, PC value after reset.
REQ-004 i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_en  input  1  step enable; low = PC, stack and error hold.
REQ-007 i_opcode  input  3  branch operation (REQ-014).
REQ-008 i_target  input  ADDR_W  jump/call destination.
REQ-009 i_status  input  3  ALU flags: [0] zero, [1] negative, [2] carry out.
REQ-010 i_flag_we  input  1  latch i_status into flag register.
REQ-011 o_pc  output  ADDR_W  registered program counter.
REQ-012 o_jump  output  1  combinational: current opcode redirects PC this cycle (i_en high, condition true, stack legal).
REQ-013 o_flags 3, o_depth clog2(STACK_DEPTH)+1, o_full 1, o_empty 1, o_err 1 -- outputs: latched flags, stack occupancy, stack full/empty, sticky stack error.

Function
REQ-014 Opcodes: 000 NEXT, 001 GOTO, 010 GTIFZ, 011 GTIFN, 100 GTIFC, 101 GTIFNZ (zero clear), 110 CALL, 111 RET.
REQ-015 Conditions evaluated against the flag register contents before this edge, never against i_status directly.
REQ-016 Simultaneous i_flag_we and conditional branch: branch uses old flags; new flags visible next cycle.
REQ-017 i_flag_we latches i_status regardless of i_en.
REQ-018 i_en high, no jump: o_pc <= o_pc + 1, wrapping modulo 2^ADDR_W (all-ones -> 0).
REQ-019 i_en high, GOTO or true condition: o_pc <= i_target, 1-cycle latency.
REQ-020 CALL, stack not full: push o_pc + 1 (wrapped), o_pc <= i_target, depth +1.
REQ-021 RET, stack not empty: pop top, o_pc <= popped value, depth -1.
REQ-022 CALL when full: no push, o_jump low, o_pc <= o_pc + 1, o_err set.
REQ-023 RET when empty: no pop, o_jump low, o_pc <= o_pc + 1, o_err set.
REQ-024 o_err sticky; cleared only by reset.
REQ-025 o_full = (depth == STACK_DEPTH); o_empty = (depth == 0); both derived from registered depth.
REQ-026 i_en low: o_jump low, no PC/stack/err change, opcode ignored.

Reset
REQ-027 i_rst high at edge: o_pc = RESET_PC, flags = 000, depth = 0, o_empty = 1, o_full = 0, o_err = 0.
REQ-028 Reset wins over i_en, i_flag_we and any opcode in the same cycle, including mid CALL/RET sequences; stack contents are don't-care after reset.

Configuration
REQ-029 Macro BRANCH_STACK_EN defined: stack, CALL, RET per REQ-020..REQ-025.
REQ-030 Macro absent: no stack storage; CALL behaves as GOTO, RET as NEXT; o_depth = 0, o_empty = 1, o_full = 0, o_err = 0 constant.

Verification
REQ-031 Reset then 256 NEXT cycles (ADDR_W=8) -> o_pc 0,1,...,255,0; wrap with no error.
REQ-032 Flag write 001 then GTIFZ target 0x40 -> o_jump high, o_pc = 0x40 next cycle; flags 000 + GTIFZ -> o_pc + 1.
REQ-033 Same cycle: i_flag_we with status 001 and GTIFZ while flags 000 -> no jump; GTIFZ next cycle -> jump.
REQ-034 With BRANCH_STACK_EN: CALL from pc 0x10 to 0x80, RET -> o_pc 0x80 then 0x11, depth 1 then 0.
REQ-035 Five CALLs (STACK_DEPTH=4) -> fifth: no jump, o_full stays 1, o_err = 1; five RETs -> four correct returns, fifth o_pc + 1, o_err remains 1.
REQ-036 i_en low with GOTO 0x33 for 3 cycles -> o_pc constant, o_jump low; reset asserted mid-CALL -> o_pc = RESET_PC, depth 0, o_err 0.
